// File: rtl/bf_pkg.sv
// Shared definitions for the data-RAM arbiter slice: port select and lock
// state encodings plus default widths.
package bf_pkg;

  // Which requester owns an access slot.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // CPU lock ownership of the RAM.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED_A = 1'b1
  } lock_e;

  localparam int DEF_DATA_ADDR_WIDTH = 15;

  // Host wait counter width; it saturates at its all-ones value (255).
  localparam int                    WAIT_CNT_W   = 8;
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

endpackage

// File: rtl/bf_arb_wait_counter.sv
// Host (port B) wait counter: counts consecutive denied cycles while B
// requests, saturating at 255, and flags when the forced-grant threshold
// MAX_WAIT has been reached.
module bf_arb_wait_counter
  import bf_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  req,
  input  logic                  gnt,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  expired
);

  localparam logic [WAIT_CNT_W-1:0] THRESH = WAIT_CNT_W'(MAX_WAIT);

  // Count denied request cycles; any grant or dropped request restarts the count.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (cnt != WAIT_CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Threshold compare used by the force rule.
  always_comb begin
    expired = (cnt >= THRESH);
  end

endmodule

// File: rtl/bf_dram_arbiter.sv
// Arbiter for the single-port synchronous-read data RAM, shared by the CPU
// (port A) and the host/debug port (port B).
//
// Handshake (both ports): a requester holds x_req and its command fields;
// the access happens in the cycle where x_req & x_gnt, and x_gnt is
// combinational. For an accepted read, x_rvalid is high for exactly one
// cycle on the next cycle, with x_rdata taken straight from the RAM.
//
// Build option: define BF_ARB_ROUND_ROBIN_EN to alternate winners on
// simultaneous requests; otherwise the CPU wins ties and the host relies on
// the MAX_WAIT force rule.
module bf_dram_arbiter
  import bf_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = DEF_DATA_ADDR_WIDTH,
  parameter int MAX_WAIT        = 15
) (
  input  logic                       clk,
  input  logic                       rst_i,
  // CPU port
  input  logic                       a_req,
  input  logic                       a_we,
  input  logic                       a_lock,
  input  logic [DATA_ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]                 a_wdata,
  output logic                       a_gnt,
  output logic                       a_rvalid,
  output logic [7:0]                 a_rdata,
  // Host port
  input  logic                       b_req,
  input  logic                       b_we,
  input  logic [DATA_ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]                 b_wdata,
  output logic                       b_gnt,
  output logic                       b_rvalid,
  output logic [7:0]                 b_rdata,
  // RAM side
  output logic [DATA_ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]                 ram_wdata,
  output logic                       ram_we,
  input  logic [7:0]                 ram_rdata,
  // Debug visibility of internal state
  output lock_e                      dbg_lock,
  output logic [WAIT_CNT_W-1:0]      dbg_wait_cnt,
  output port_e                      dbg_last_winner
);

  lock_e                      lock_q, lock_d;
  port_e                      last_q;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [WAIT_CNT_W-1:0]      wait_cnt;
  logic                       wait_expired;

  bf_arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst_i  (rst_i),
    .req    (b_req),
    .gnt    (b_gnt),
    .cnt    (wait_cnt),
    .expired(wait_expired)
  );

  // Grant decision: lock first, then host starvation force, then single
  // requester, then the tie-break policy.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (lock_q == LOCKED_A) begin
      a_gnt = a_req;
    end else if (wait_expired && b_req) begin
      b_gnt = 1'b1;
    end else if (a_req && !b_req) begin
      a_gnt = 1'b1;
    end else if (b_req && !a_req) begin
      b_gnt = 1'b1;
    end else if (a_req && b_req) begin
`ifdef BF_ARB_ROUND_ROBIN_EN
      if (last_q == PORT_A) begin
        b_gnt = 1'b1;
      end else begin
        a_gnt = 1'b1;
      end
`else
      a_gnt = 1'b1;
`endif
    end
  end

  // RAM command mux; with no access the address parks on the last used value.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = a_wdata;
    ram_we    = 1'b0;
    if (a_gnt) begin
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
      ram_we    = a_we;
    end else if (b_gnt) begin
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
      ram_we    = b_we;
    end
  end

  // Lock FSM next state: an accepted CPU access sets or releases ownership.
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: if (a_gnt && a_lock)  lock_d = LOCKED_A;
      LOCKED_A: if (a_gnt && !a_lock) lock_d = UNLOCKED;
      default:  lock_d = UNLOCKED;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      lock_q <= UNLOCKED;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Read-valid pulses, last winner and parked address.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      last_q   <= PORT_B;
      addr_q   <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt) begin
        last_q <= PORT_A;
        addr_q <= a_addr;
      end else if (b_gnt) begin
        last_q <= PORT_B;
        addr_q <= b_addr;
      end
    end
  end

  // Read data is a passthrough of the RAM output to both ports.
  always_comb begin
    a_rdata         = ram_rdata;
    b_rdata         = ram_rdata;
    dbg_lock        = lock_q;
    dbg_wait_cnt    = wait_cnt;
    dbg_last_winner = last_q;
  end

endmodule

// File: tb/tb_bf_dram_arbiter.sv
// Self-checking bench for bf_dram_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_bf_dram_arbiter;

  localparam int AW       = 15;
  localparam int MAX_WAIT = 15;
  localparam int DEPTH    = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i;

  logic          a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [7:0]    a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [7:0]    b_wdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          ram_we;
  logic          dbg_lock, dbg_last_winner;
  logic [7:0]    dbg_wait_cnt;

  bf_dram_arbiter #(.DATA_ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_i(rst_i),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .dbg_lock(dbg_lock), .dbg_wait_cnt(dbg_wait_cnt), .dbg_last_winner(dbg_last_winner)
  );

  // Synchronous-read, read-before-write data RAM.
  logic [7:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // ---------------- reference model state ----------------
  logic [7:0]    m_mem [0:DEPTH-1];
  bit            m_lock;
  int            m_wait;
  bit            m_last_b;
  bit            m_addr_known;
  logic [AW-1:0] m_addr;
  logic [7:0]    exp_a_q[$];
  logic [7:0]    exp_b_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit seen_a_gnt, seen_b_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lock       = 1'b0;
    m_wait       = 0;
    m_last_b     = 1'b1;
    m_addr_known = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  // ---------------- driver + model for one clock cycle ----------------
  // Called just after an active edge; drives, checks combinational outputs,
  // advances the model, crosses the edge and checks registered outputs.
  task automatic cycle(input logic ar, input logic aw, input logic al,
                       input logic [AW-1:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw,
                       input logic [AW-1:0] ba, input logic [7:0] bd);
    bit wa, wb, exp_arv, exp_brv;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_data, d;
    logic          w_we;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    wa = 1'b0;
    wb = 1'b0;
    if (m_lock) wa = ar;
    else if (m_wait >= MAX_WAIT && br) wb = 1'b1;
    else if (ar && br) begin
`ifdef BF_ARB_ROUND_ROBIN_EN
      wa = m_last_b;
      wb = !m_last_b;
`else
      wa = 1'b1;
`endif
    end else begin
      wa = ar;
      wb = br;
    end
    chk("a_gnt", a_gnt, wa);
    chk("b_gnt", b_gnt, wb);
    seen_a_gnt = a_gnt;
    seen_b_gnt = b_gnt;
    exp_arv = wa && !aw;
    exp_brv = wb && !bw;
    if (wa || wb) begin
      w_addr = wa ? aa : ba;
      w_data = wa ? ad : bd;
      w_we   = wa ? aw : bw;
      chk("ram_addr", ram_addr, w_addr);
      chk("ram_we", ram_we, w_we);
      if (w_we) begin
        chk("ram_wdata", ram_wdata, w_data);
        m_mem[w_addr] = w_data;
      end else if (wa) exp_a_q.push_back(m_mem[w_addr]);
      else exp_b_q.push_back(m_mem[w_addr]);
      m_addr       = w_addr;
      m_addr_known = 1'b1;
      m_last_b     = wb;
    end else begin
      chk("ram_we_idle", ram_we, 1'b0);
      if (m_addr_known) chk("ram_addr_hold", ram_addr, m_addr);
    end
    if (wa) m_lock = al;
    m_wait = (br && !wb) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    @(posedge clk);
    #1;
    chk("a_rvalid", a_rvalid, exp_arv);
    chk("b_rvalid", b_rvalid, exp_brv);
    if (exp_arv) begin
      d = exp_a_q.pop_front();
      chk("a_rdata", a_rdata, d);
    end
    if (exp_brv) begin
      d = exp_b_q.pop_front();
      chk("b_rdata", b_rdata, d);
    end
    chk("wait_cnt", dbg_wait_cnt, m_wait);
    chk("lock", dbg_lock, m_lock);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          ar, aw, al;
    logic [AW-1:0] aa;
    logic [7:0]    ad;
    logic          br, bw;
    logic [AW-1:0] ba;
    logic [7:0]    bd;
    logic          ea_gnt, eb_gnt, ea_rv, eb_rv;
    logic [7:0]    e_rdata;
  } vec_t;

  vec_t tbl[11];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    logic ar, aw, al, br, bw;
    logic [AW-1:0] aa, ba;
    logic [7:0] ad, bd;
    bit exp_b;

    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      ram[i]   = v;
      m_mem[i] = v;
    end
    ram[15'h0010] = 8'h5A; m_mem[15'h0010] = 8'h5A;
    ram[15'h0003] = 8'h33; m_mem[15'h0003] = 8'h33;
    ram[15'h0007] = 8'h11; m_mem[15'h0007] = 8'h11;

    //                ar    aw    al    aa        ad     br    bw    ba        bd     ag    bg    arv   brv   rdata
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 15'h0010, 8'h00, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 15'h0003, 8'h00, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 15'h0003, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 15'h0003, 8'h44, 1'b1, 1'b0, 15'h0003, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 15'h0003, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 15'h0007, 8'h00, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 15'h0007, 8'h22, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 15'h0007, 8'h00, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b1, 15'h0100, 8'h9C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 1'b0, 15'h0100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h9C};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // ---- reset state ----
    rst_i = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    model_reset();
    #12;
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_b_gnt", b_gnt, 1'b0);
    chk("rst_lock", dbg_lock, 1'b0);
    chk("rst_wait", dbg_wait_cnt, 8'd0);
    chk("rst_last_is_b", dbg_last_winner, 1'b1);
    #5 rst_i = 1'b1;
    @(posedge clk);
    #1;

    // ---- directed table: single requester, lock handoff, read-before-write ----
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].ar, tbl[i].aw, tbl[i].al, tbl[i].aa, tbl[i].ad,
            tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd);
      chk("tbl_a_gnt", seen_a_gnt, tbl[i].ea_gnt);
      chk("tbl_b_gnt", seen_b_gnt, tbl[i].eb_gnt);
      chk("tbl_a_rvalid", a_rvalid, tbl[i].ea_rv);
      chk("tbl_b_rvalid", b_rvalid, tbl[i].eb_rv);
      if (tbl[i].ea_rv) chk("tbl_a_rdata", a_rdata, tbl[i].e_rdata);
      if (tbl[i].eb_rv) chk("tbl_b_rdata", b_rdata, tbl[i].e_rdata);
    end

    // ---- simultaneous requests: tie-break policy and force rule ----
    for (int k = 0; k < 16; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 15'h0001, 8'h00, 1'b1, 1'b0, 15'h0002, 8'h00);
`ifdef BF_ARB_ROUND_ROBIN_EN
      exp_b = (k % 2) == 1;
`else
      exp_b = (k == 15);
`endif
      chk("sim_b_wins", seen_b_gnt, exp_b);
      chk("sim_a_wins", seen_a_gnt, !exp_b);
    end
    idle();

    // ---- lock starvation: B blocked for 20 idle locked cycles ----
    cycle(1'b1, 1'b0, 1'b1, 15'h0005, 8'h00, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h0005, 8'h00);
      chk("starve_b_gnt", seen_b_gnt, 1'b0);
    end
    chk("starve_cnt", dbg_wait_cnt, 8'd20);
    cycle(1'b1, 1'b1, 1'b0, 15'h0005, 8'h77, 1'b1, 1'b0, 15'h0005, 8'h00);
    chk("unlock_a_gnt", seen_a_gnt, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 15'h0005, 8'h00, 1'b1, 1'b0, 15'h0005, 8'h00);
    chk("unlock_b_forced", seen_b_gnt, 1'b1);
    chk("unlock_b_rdata", b_rdata, 8'h77);
    idle();

    // ---- randomized traffic against the model ----
    for (int k = 0; k < 400; k++) begin
      ar = 1'($urandom_range(0, 1));
      aw = 1'($urandom_range(0, 1));
      al = ($urandom_range(0, 5) == 0);
      aa = AW'($urandom_range(0, 15));
      ad = 8'($urandom);
      br = ($urandom_range(0, 3) != 0);
      bw = 1'($urandom_range(0, 1));
      ba = AW'($urandom_range(0, 15));
      bd = 8'($urandom);
      cycle(ar, aw, al, aa, ad, br, bw, ba, bd);
    end
    // Release any lock left from the random phase.
    cycle(1'b1, 1'b0, 1'b0, 15'h0010, 8'h00, 1'b0, 1'b0, '0, '0);
    idle();

    // ---- async reset right after an accepted locked read ----
    cycle(1'b1, 1'b0, 1'b1, 15'h0007, 8'h00, 1'b0, 1'b0, '0, '0);
    chk("pre_rst_lock", dbg_lock, 1'b1);
    a_req = 1'b0; a_lock = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_a_rvalid", a_rvalid, 1'b0);
    chk("mid_rst_lock", dbg_lock, 1'b0);
    model_reset();
    #3 rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_a_rvalid", a_rvalid, 1'b0);
    idle();
    idle();

    // ---- async reset with a read in flight: the read is lost ----
    a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
    #1;
    chk("inflight_a_gnt", a_gnt, 1'b1);
    #1 rst_i = 1'b0;
    a_req = 1'b0;
    @(posedge clk);
    #1;
    chk("inflight_lost", a_rvalid, 1'b0);
    model_reset();
    #2 rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("inflight_no_late_rvalid", a_rvalid, 1'b0);
    // First tie after reset goes to A in both builds.
    cycle(1'b1, 1'b0, 1'b0, 15'h0010, 8'h00, 1'b1, 1'b0, 15'h0003, 8'h00);
    chk("post_rst_tie_a", seen_a_gnt, 1'b1);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bf_dram_arbiter.md
Name: bf_dram_arbiter

Overview:
- Shares the single-port, synchronous-read data RAM between two requesters: the CPU (port A) and a host/debug access port (port B).
- Grants at most one access per cycle and drives the RAM address, write-data and write-enable.
- Returns read data to the winning requester one cycle later.
- Supports locked sequences so the CPU can read-modify-write a cell atomically, and bounds host wait time.

Parameters:
- DATA_ADDR_WIDTH, 15, data RAM address width.
- MAX_WAIT, 15, max cycles port B may be denied before it is forced to win. Range 1..255.

Ports:
- clk  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- a_req  in  1  CPU access request.
- a_we  in  1  CPU write (1) / read (0).
- a_lock  in  1  CPU holds ownership after this access.
- a_addr  in  DATA_ADDR_WIDTH  CPU address.
- a_wdata  in  8  CPU write data.
- a_gnt  out  1  CPU access accepted this cycle (combinational).
- a_rvalid  out  1  CPU read data valid.
- a_rdata  out  8  CPU read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for the host. Port B has no lock.
- ram_addr  out  DATA_ADDR_WIDTH  to RAM addr.
- ram_wdata  out  8  to RAM data_write.
- ram_we  out  1  to RAM we.
- ram_rdata  in  8  from RAM data_read (valid one cycle after address).

Behaviour:
- Reset (rst_i=0, async): a_rvalid=b_rvalid=0, lock owner=none, last winner=B, wait counter=0. a_gnt=b_gnt=0 because no request is assumed during reset.
- Grant is combinational from requests plus registered state:
  - Locked to A: only A can win; b_gnt=0.
  - Otherwise, wait counter >= MAX_WAIT and b_req: B wins.
  - Otherwise, only one request: that requester wins.
  - Otherwise, both request: priority policy (see Optional Feature).
- Accepted access (x_req & x_gnt): ram_addr/ram_wdata/ram_we = x_addr/x_wdata/x_we.
- No access: ram_we=0, ram_addr holds the last value (registered copy); ram_wdata don't-care.
- Read latency is 1 cycle:
  - x_rvalid is registered high for exactly one cycle after an accepted read, never after a write.
  - x_rdata = ram_rdata (passthrough), meaningful only while x_rvalid=1.
- Lock states:
  - UNLOCKED: A accepted with a_lock=1 -> LOCKED_A.
  - LOCKED_A: A accepted with a_lock=0 -> UNLOCKED.
  - LOCKED_A: a_req=0 keeps LOCKED_A (B stays blocked). A must not idle while locked longer than intended.
- Wait counter:
  - Increments, saturating at 255, each cycle b_req=1 & b_gnt=0.
  - Clears when B is accepted or b_req=0.
  - Force rule (wait counter >= MAX_WAIT) does not override LOCKED_A; the counter keeps counting during the lock.
- Last winner register updates on every accepted access.
- Read followed by a write to the same address in consecutive cycles: the read returns the old value (RAM read-before-write).
- Reset mid-access: rvalid is cleared, lock is dropped, and an in-flight read is lost.

Optional Feature:
- Macro: BF_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in UNLOCKED, the port that did not win last accepted access wins.
- Undefined: on simultaneous requests, A (CPU) always wins; B progresses only via the MAX_WAIT force rule.
- The lock and force rules are identical in both builds.

Decomposition:
- Shared package bf_pkg:
  - Port select encoding: PORT_A=1'b0, PORT_B=1'b1.
  - Lock state encoding: UNLOCKED, LOCKED_A.
  - Default DATA_ADDR_WIDTH constant.
- One natural sub-module: bf_arb_wait_counter. It is the saturating counter with clear and a threshold compare output.

Test Plan:
- Single requester: A reads addr 0x0010, which holds 0x5A -> a_gnt same cycle; a_rvalid=1 and a_rdata=0x5A next cycle; b_rvalid stays 0.
- Simultaneous requests, A reads 0x0001 and B reads 0x0002:
  - Fixed build: A wins every cycle until the wait counter reaches 15, then B wins once.
  - Round-robin build: winners alternate A,B,A,B.
- Lock, two steps:
  - Step 1: A reads 0x0003 with a_lock=1; B requests continuously -> b_gnt=0.
  - Step 2: A writes 0x44 with a_lock=0 -> B is granted the next cycle, and a B read of 0x0003 returns 0x44.
- Lock starvation: A holds the lock 20 idle cycles while B requests -> b_gnt=0 throughout, counter=20; B is granted immediately after unlock.
- Back-to-back accesses to 0x0007 (holds 0x11): A reads, then A writes 0x22 the next cycle -> the read returns 0x11; a later read returns 0x22.
- Async reset mid-operation: assert rst_i=0 between clock edges after an accepted read -> a_rvalid=0 immediately, lock cleared, no rvalid after release.
